adder_mp_seq: RTL and testbench

Multi-precision add/subtract sequencer that time-shares a single `adder_full_n` slice to add or subtract operands `WORDS` times wider than the slice. It latches two wide operands on a start request, then feeds one n-bit slice per cycle through the adder, least-significant first. Between slices it holds the slice carry in a register, and it reports completion with a one-cycle `done` pulse. It sits between a control FSM or CPU-side register file and the existing ripple adder datapath.

---
 rtl/adder_mp_seq_pkg.sv | 19 +
 rtl/adder_mp_seq_adder_full_n.sv | 24 ++
 rtl/adder_mp_seq.sv | 120 ++++++++++++
 tb/tb_adder_mp_seq.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/adder_mp_seq_pkg.sv
// Shared adder-sequencer definitions: FSM state encoding, opcode values and
// the carry-seed helper, kept here so future ALU sequencers can reuse them.
package adder_mp_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Subtract is A + ~B + 1, so the first slice always sees a carry of 1.
    function automatic logic op_carry_seed(input logic sub, input logic cin);
        return (sub == OP_SUB) ? 1'b1 : cin;
    endfunction

endpackage

// File: rtl/adder_mp_seq_adder_full_n.sv
// n-bit ripple-carry adder slice; the single datapath element that the
// multi-precision sequencer time-shares.
module adder_full_n #(
    parameter int n = 8
) (
    input  logic [n-1:0] x,
    input  logic [n-1:0] y,
    input  logic         cin,
    output logic [n-1:0] s,
    output logic         cout
);

    always_comb begin
        logic c;
        c = cin;
        s = '0;
        for (int i = 0; i < n; i++) begin
            s[i] = x[i] ^ y[i] ^ c;
            c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
        end
        cout = c;
    end

endmodule

// File: rtl/adder_mp_seq.sv
// Multi-precision add/subtract sequencer: walks WORDS slices of the latched
// operands through one adder_full_n, least-significant slice first.
module adder_mp_seq
    import adder_mp_seq_pkg::*;
#(
    parameter int n     = 8,
    parameter int WORDS = 4,
    localparam int W    = n * WORDS,
    localparam int IW   = $clog2(WORDS)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         sub,
    input  logic         cin,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         ovf
);

    state_e          state_q;
    logic [W-1:0]    a_q, b_q;
    logic            sub_q;
    logic            carry_q;
    logic [IW-1:0]   idx_q;
    logic [W-1:0]    sum_q;
    logic            cout_q, ovf_q, busy_q, done_q;

    logic [n-1:0]    x_slice, y_slice, s_slice;
    logic            c_slice;
    logic            last;
    logic [W-1:0]    sum_d;
    logic [IW-1:0]   idx_d;
    logic            ovf_d;

    assign x_slice = a_q[idx_q*n +: n];
    assign y_slice = b_q[idx_q*n +: n] ^ {n{sub_q}};
    assign last    = (idx_q == IW'(WORDS - 1));

    adder_full_n #(.n(n)) u_slice (
        .x    (x_slice),
        .y    (y_slice),
        .cin  (carry_q),
        .s    (s_slice),
        .cout (c_slice)
    );

    always_comb begin
        sum_d = sum_q;
        sum_d[idx_q*n +: n] = s_slice;
        // Index saturates on the last slice so it never wraps.
        idx_d = last ? idx_q : idx_q + IW'(1);
        // Carry into the MSB xor carry out of it.
        ovf_d = x_slice[n-1] ^ y_slice[n-1] ^ s_slice[n-1] ^ c_slice;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sub_q   <= 1'b0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q     <= A;
                        b_q     <= B;
                        sub_q   <= sub;
                        carry_q <= op_carry_seed(sub, cin);
                        idx_q   <= '0;
                        sum_q   <= '0;
                        cout_q  <= 1'b0;
                        ovf_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= ST_RUN;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    sum_q   <= sum_d;
                    carry_q <= c_slice;
                    idx_q   <= idx_d;
                    if (last) begin
                        cout_q  <= c_slice;
                        ovf_q   <= ovf_d;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_adder_mp_seq.sv
// Self-checking bench for adder_mp_seq: directed cases plus random operations
// checked against a whole-word arithmetic reference.
module tb_adder_mp_seq;

    localparam int N     = 8;
    localparam int WORDS = 4;
    localparam int W     = N * WORDS;

    logic         clk = 1'b0;
    logic         rst, start, sub, cin;
    logic [W-1:0] A, B, sum;
    logic         busy, done, cout, ovf;

    int compared   = 0;
    int mismatched = 0;

    adder_mp_seq #(.n(N), .WORDS(WORDS)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .sub   (sub),
        .cin   (cin),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Ticks until done is seen or the budget runs out; returns cycles used.
    task automatic wait_done(output int cyc);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (!done && cyc < 20);
    endtask

    // Whole-word reference: {ovf, cout, sum}.
    function automatic logic [W+1:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic s, input logic c);
        logic [W-1:0] y;
        logic [W:0]   r;
        logic         c0, v;
        y  = s ? ~b : b;
        c0 = s ? 1'b1 : c;
        r  = {1'b0, a} + {1'b0, y} + {{W{1'b0}}, c0};
        v  = (a[W-1] == y[W-1]) && (r[W-1] != a[W-1]);
        return {v, r};
    endfunction

    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic s, input logic c);
        logic [W+1:0] r;
        int cyc;
        A = a; B = b; sub = s; cin = c; start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, "/busy"}, busy, 1);
        wait_done(cyc);
        chk({tag, "/latency"}, cyc, WORDS);
        r = ref_op(a, b, s, c);
        chk({tag, "/sum"}, sum, r[W-1:0]);
        chk({tag, "/cout"}, cout, r[W]);
        chk({tag, "/ovf"}, ovf, r[W+1]);
        chk({tag, "/busy_end"}, busy, 0);
        tick();
        chk({tag, "/done_pulse"}, done, 0);
    endtask

    initial begin
        logic [W+1:0] r;
        int cyc, ndone;

        rst = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0; A = '0; B = '0;
        tick();
        tick();
        chk("rst/busy", busy, 0);
        chk("rst/done", done, 0);
        chk("rst/sum", sum, 0);
        chk("rst/cout", cout, 0);
        chk("rst/ovf", ovf, 0);
        rst = 1'b0;
        ndone = 0;
        repeat (5) begin
            tick();
            if (done) ndone++;
        end
        chk("idle/no_done", ndone, 0);
        chk("idle/busy", busy, 0);

        run_op("ripple", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        chk("ripple/sum_abs", sum, 32'h0000_0000);
        run_op("ovf_add", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        chk("ovf_add/sum_abs", sum, 32'h8000_0000);
        chk("ovf_add/ovf_abs", ovf, 1);
        run_op("sub_neg", 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0);
        chk("sub_neg/sum_abs", sum, 32'hFFFF_FFFE);
        chk("sub_neg/cout_abs", cout, 0);
        run_op("sub_ovf", 32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1);
        chk("sub_ovf/sum_abs", sum, 32'h7FFF_FFFF);
        chk("sub_ovf/cout_abs", cout, 1);
        chk("sub_ovf/ovf_abs", ovf, 1);

        // start pulsed 2 cycles into RUN must be ignored
        A = 32'h0102_0304; B = 32'h1020_3040; sub = 1'b0; cin = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        A = 32'hDEAD_BEEF; B = 32'hCAFE_F00D; sub = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(cyc);
        chk("runstart/latency", cyc, 1);
        chk("runstart/sum", sum, 32'h1122_3345);
        ndone = 0;
        repeat (10) begin
            tick();
            if (done) ndone++;
        end
        chk("runstart/extra_done", ndone, 0);

        // back-to-back: start held through DONE
        A = 32'h0000_00FF; B = 32'h0000_0001; sub = 1'b0; cin = 1'b0; start = 1'b1;
        tick();
        A = 32'h1234_5678; B = 32'h1111_1111;
        wait_done(cyc);
        chk("b2b/first_latency", cyc, WORDS);
        chk("b2b/first_sum", sum, 32'h0000_0100);
        tick();
        start = 1'b0;
        chk("b2b/reaccept_busy", busy, 1);
        chk("b2b/reaccept_done", done, 0);
        wait_done(cyc);
        chk("b2b/gap", cyc + 1, WORDS + 1);
        chk("b2b/sum", sum, 32'h2345_6789);
        tick();

        // reset one cycle after slice 1 commits
        A = 32'h0000_1234; B = 32'h0000_1111; sub = 1'b0; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("abort/partial", sum[15:0], 16'h2345);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort/sum", sum, 0);
        chk("abort/busy", busy, 0);
        chk("abort/done", done, 0);
        ndone = 0;
        repeat (8) begin
            tick();
            if (done) ndone++;
        end
        chk("abort/no_done", ndone, 0);
        run_op("after_abort", 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0);
        chk("after_abort/sum_abs", sum, 32'h0000_0002);

        for (int i = 0; i < 30; i++) begin
            logic [W-1:0] ra, rb;
            ra = $urandom;
            rb = $urandom;
            if (i % 7 == 0) rb = ~ra;
            if (i % 11 == 0) ra = 32'h8000_0000;
            run_op("rand", ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
